// File: rtl/updown_mod_counter_pkg.sv
// Shared constants and helpers for the JK-based modulo-N up/down counter.
package updown_mod_counter_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Returns {j, k} that move one JK cell from cur to nxt on the next edge.
    function automatic logic [1:0] jk_from(input logic cur, input logic nxt);
        return {nxt & ~cur, ~nxt & cur};
    endfunction

endpackage

// File: rtl/updown_mod_counter_if.sv
// Control/status bundle for updown_mod_counter; the master drives controls, the counter drives status.
interface updown_mod_counter_if #(
    parameter int WIDTH = 4
);
    // Level-sampled controls, no handshake: every falling edge of clk consumes
    // en/up_dn/load/load_val as they stand; tc is combinational from q, en, up_dn.
    logic             en;
    logic             up_dn;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] q;
    logic             tc;
    logic             load_err;

    modport master (
        output en, up_dn, load, load_val,
        input  q, tc, load_err
    );

    modport slave (
        input  en, up_dn, load, load_val,
        output q, tc, load_err
    );

endinterface

// File: rtl/updown_mod_counter_jk_cell.sv
// Single JK flip-flop on the falling clock edge with synchronous active-high clear.
module jk_cell (
    input  logic clk,
    input  logic reset,
    input  logic j,
    input  logic k,
    output logic q
);

    always_ff @(negedge clk) begin
        if (reset) begin
            q <= 1'b0;
        end else begin
            case ({j, k})
                2'b00:   q <= q;
                2'b01:   q <= 1'b0;
                2'b10:   q <= 1'b1;
                default: q <= ~q;
            endcase
        end
    end

endmodule

// File: rtl/updown_mod_counter.sv
// Synchronous modulo-N up/down counter: next-state logic drives one JK cell per bit.
module updown_mod_counter
    import updown_mod_counter_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic               clk,
    input  logic               reset,
    updown_mod_counter_if.slave bus
);

    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   MOD_W = (WIDTH + 1)'(MODULUS);

    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] next_q;
    logic [WIDTH-1:0] j_bits;
    logic [WIDTH-1:0] k_bits;
    logic             load_ok;
    logic             load_err;

    assign load_ok = ({1'b0, bus.load_val} < MOD_W);

    always_comb begin
        next_q = q;
        if (bus.load) begin
            if (load_ok) begin
                next_q = bus.load_val;
            end
        end else if (bus.en) begin
            // Any out-of-range state falls back to 0 so the counter cannot lock up.
            if (q > MAX_Q) begin
                next_q = '0;
            end else if (bus.up_dn == DIR_UP) begin
                next_q = (q == MAX_Q) ? '0 : q + WIDTH'(1);
            end else begin
                next_q = (q == '0) ? MAX_Q : q - WIDTH'(1);
            end
        end
    end

    always_comb begin
        j_bits = '0;
        k_bits = '0;
        for (int i = 0; i < WIDTH; i++) begin
            {j_bits[i], k_bits[i]} = jk_from(q[i], next_q[i]);
        end
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_cell
        jk_cell u_cell (
            .clk   (clk),
            .reset (reset),
            .j     (j_bits[g]),
            .k     (k_bits[g]),
            .q     (q[g])
        );
    end

    always_ff @(negedge clk) begin
        if (reset) begin
            load_err <= 1'b0;
        end else if (bus.load && !load_ok) begin
            load_err <= 1'b1;
        end
    end

    assign bus.q        = q;
    assign bus.load_err = load_err;
    assign bus.tc       = bus.en & (((bus.up_dn == DIR_UP) & (q == MAX_Q)) |
                                    ((bus.up_dn == DIR_DOWN) & (q == '0)));

endmodule

// File: tb/tb_updown_mod_counter.sv
// Self-checking bench for updown_mod_counter (WIDTH=4, MODULUS=10) plus a two-digit cascade.
module tb_updown_mod_counter;

    localparam int WIDTH   = 4;
    localparam int MODULUS = 10;

    // Clock and reset
    logic clk = 1'b0;
    logic reset;
    logic c_reset;
    always #5 clk = ~clk;

    updown_mod_counter_if #(.WIDTH(WIDTH)) cif ();
    updown_mod_counter_if #(.WIDTH(WIDTH)) lo_if ();
    updown_mod_counter_if #(.WIDTH(WIDTH)) hi_if ();

    updown_mod_counter #(.WIDTH(WIDTH), .MODULUS(MODULUS)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (cif.slave)
    );

    updown_mod_counter #(.WIDTH(WIDTH), .MODULUS(MODULUS)) u_lo (
        .clk   (clk),
        .reset (c_reset),
        .bus   (lo_if.slave)
    );

    updown_mod_counter #(.WIDTH(WIDTH), .MODULUS(MODULUS)) u_hi (
        .clk   (clk),
        .reset (c_reset),
        .bus   (hi_if.slave)
    );

    assign hi_if.en = lo_if.tc;

    // Scoreboard state
    logic [WIDTH:0] exp_q[$];
    int             checks = 0;
    int             errors = 0;
    int             m_q    = 0;
    logic           m_err  = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one falling-edge cycle on the main DUT and score it.
    task automatic drive(input logic r, input logic ld, input logic [WIDTH-1:0] lv,
                         input logic e, input logic ud, input string tag);
        logic           exp_tc;
        logic [WIDTH:0] exp_v;
        @(posedge clk);
        reset        = r;
        cif.load     = ld;
        cif.load_val = lv;
        cif.en       = e;
        cif.up_dn    = ud;
        #1;
        exp_tc = e && ((ud && m_q == MODULUS - 1) || (!ud && m_q == 0));
        check({tag, "_tc"}, 32'(cif.tc), 32'(exp_tc));
        if (r) begin
            m_q   = 0;
            m_err = 1'b0;
        end else if (ld) begin
            if (int'(lv) < MODULUS) m_q = int'(lv);
            else m_err = 1'b1;
        end else if (e) begin
            m_q = ud ? (m_q + 1) % MODULUS : (m_q + MODULUS - 1) % MODULUS;
        end
        exp_q.push_back({m_err, WIDTH'(m_q)});
        @(negedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check({tag, "_empty"}, 32'(1), 32'(0));
        end else begin
            exp_v = exp_q.pop_front();
            check({tag, "_q"}, 32'({cif.load_err, cif.q}), 32'(exp_v));
        end
    endtask

    task automatic cascade_step(input logic r, input logic e, input int exp_val, input string tag);
        @(posedge clk);
        c_reset  = r;
        lo_if.en = e;
        @(negedge clk);
        #1;
        check(tag, 32'(int'(hi_if.q) * 10 + int'(lo_if.q)), 32'(exp_val));
    endtask

    initial begin
        reset          = 1'b0;
        c_reset        = 1'b0;
        cif.en         = 1'b0;
        cif.up_dn      = 1'b1;
        cif.load       = 1'b0;
        cif.load_val   = '0;
        lo_if.en       = 1'b0;
        lo_if.up_dn    = 1'b1;
        lo_if.load     = 1'b0;
        lo_if.load_val = '0;
        hi_if.up_dn    = 1'b1;
        hi_if.load     = 1'b0;
        hi_if.load_val = '0;

        drive(1, 0, 0, 0, 1, "reset");
        for (int i = 0; i < 12; i++) drive(0, 0, 0, 1, 1, "up");

        drive(1, 0, 0, 0, 0, "reset2");
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 1, 0, "down");

        drive(0, 1, 4'd5, 0, 1, "load5");
        drive(0, 1, 4'd3, 1, 1, "load3_en");
        drive(0, 1, 4'd12, 0, 1, "load12_bad");
        drive(0, 0, 0, 1, 1, "err_sticky");
        drive(0, 0, 0, 1, 1, "err_sticky2");
        drive(0, 1, 4'd9, 1, 0, "load9_edge");
        drive(0, 1, 4'd10, 1, 1, "load10_bad");
        drive(1, 0, 0, 0, 1, "err_clear");

        for (int i = 0; i < 4; i++) drive(0, 0, 0, 1, 1, "to4");
        drive(0, 0, 0, 1, 0, "flip_dn");
        drive(0, 0, 0, 1, 0, "flip_dn2");
        drive(0, 0, 0, 0, 0, "hold");
        drive(0, 0, 0, 0, 1, "hold2");

        drive(0, 1, 4'd6, 0, 1, "load6");
        drive(1, 1, 4'd7, 1, 1, "reset_wins");
        drive(0, 1, 4'd15, 0, 1, "load15_bad");
        drive(1, 1, 4'd15, 1, 0, "reset_wins2");

        for (int i = 0; i < 60; i++) begin
            drive(($urandom_range(0, 19) == 0), ($urandom_range(0, 4) == 0),
                  WIDTH'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 1)), "rand");
        end

        cascade_step(1, 0, 0, "cas_reset");
        for (int i = 1; i <= 102; i++) cascade_step(0, 1, i % 100, "cascade");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
